// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the alignment check used when a request is accepted.
package mem_pkg;

  typedef enum logic [1:0] {
    DT_WORD = 2'b00,
    DT_HALF = 2'b01,
    DT_BYTE = 2'b10,
    DT_RSVD = 2'b11
  } datatype_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Width of the latency down-counter; covers LATENCY up to 15.
  localparam int CNT_W = 4;

  // An access is illegal when its size is reserved or its byte offset is not
  // naturally aligned to that size.
  function automatic logic access_err(input logic [1:0] dt, input logic [1:0] off);
    logic err;
    case (dt)
      DT_WORD: err = (off != 2'b00);
      DT_HALF: err = off[0];
      DT_BYTE: err = 1'b0;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: merges store data into the addressed word and
// extracts/extends the addressed lane of that word for loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  dtype,
  input  logic        is_unsigned,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Store merge: only the lanes selected by size and offset take new data.
  always_comb begin
    new_word = old_word;
    case (dtype)
      DT_WORD: new_word = wdata;
      DT_HALF: begin
        if (offset[1]) new_word[15:0]  = wdata[15:0];
        else           new_word[31:16] = wdata[15:0];
      end
      DT_BYTE: begin
        case (offset)
          2'd0:    new_word[31:24] = wdata[7:0];
          2'd1:    new_word[23:16] = wdata[7:0];
          2'd2:    new_word[15:8]  = wdata[7:0];
          default: new_word[7:0]   = wdata[7:0];
        endcase
      end
      default: new_word = old_word;
    endcase
  end

  // Load extract: offset 0 is the most significant lane; the lane is
  // right-justified and sign- or zero-extended.
  always_comb begin
    case (offset)
      2'd0:    byte_lane = old_word[31:24];
      2'd1:    byte_lane = old_word[23:16];
      2'd2:    byte_lane = old_word[15:8];
      default: byte_lane = old_word[7:0];
    endcase
    half_lane = offset[1] ? old_word[15:0] : old_word[31:16];
    case (dtype)
      DT_HALF: rdata = is_unsigned ? {16'h0000, half_lane}
                                   : {{16{half_lane[15]}}, half_lane};
      DT_BYTE: rdata = is_unsigned ? {24'h000000, byte_lane}
                                   : {{24{byte_lane[7]}}, byte_lane};
      default: rdata = old_word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: accepts one request, stalls the
// pipeline via Busy for LATENCY cycles, then completes with a one-cycle Ack.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2    // legal range 1..15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [1:0]  Datatype,
  input  logic        Unsigned,
  output logic        Busy,
  output logic        Ack,
  output logic [31:0] RData,
  output logic        AddrErr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  dt_q;
  logic        uns_q;

  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_dt;
  logic        cur_uns;

  logic                  accept;
  logic                  err_cur;
  logic                  enter_resp;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           old_word;
  logic [31:0]           new_word;
  logic [31:0]           load_word;
  logic                  unused_addr_hi;

  logic [31:0] mem [DEPTH];

  // In IDLE the live request fields are used so a LATENCY=1 or error access
  // can complete on the accept edge; later states use the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_wr    = Wr;
      cur_addr  = Addr;
      cur_wdata = WData;
      cur_dt    = Datatype;
      cur_uns   = Unsigned;
    end else begin
      cur_wr    = wr_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_dt    = dt_q;
      cur_uns   = uns_q;
    end
  end

  assign accept         = (state_q == IDLE) && Req;
  assign err_cur        = access_err(cur_dt, cur_addr[1:0]);
  assign word_idx       = cur_addr[ADDR_WIDTH+1:2];
  assign old_word       = mem[word_idx];
  assign enter_resp     = (state_q != RESP) && (state_d == RESP);
  // Address bits above the memory are ignored, so accesses wrap.
  assign unused_addr_hi = ^cur_addr[31:ADDR_WIDTH+2];

  mem_lane_align u_align (
    .old_word    (old_word),
    .wdata       (cur_wdata),
    .offset      (cur_addr[1:0]),
    .dtype       (cur_dt),
    .is_unsigned (cur_uns),
    .new_word    (new_word),
    .rdata       (load_word)
  );

  // Next-state, counter and handshake outputs; Busy is low in RESP so the
  // pipeline advances on Ack, and a Req seen in RESP is not accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Busy    = 1'b0;
    Ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req) begin
          Busy = 1'b1;
          if (err_cur || (LATENCY == 1)) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        Busy  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        Ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured on the accept edge and held through WAIT.
  always_ff @(posedge Clk) begin
    if (accept) begin
      wr_q    <= Wr;
      addr_q  <= Addr;
      wdata_q <= WData;
      dt_q    <= Datatype;
      uns_q   <= Unsigned;
    end
  end

  // Stores commit only on the edge into RESP, so a reset during WAIT drops
  // the write; the array itself is never cleared.
  always_ff @(posedge Clk) begin
    if (enter_resp && cur_wr && !err_cur) begin
      mem[word_idx] <= new_word;
    end
  end

  // Load result and error flag update on RESP entry and hold until the next.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RData   <= '0;
      AddrErr <= 1'b0;
    end else if (enter_resp) begin
      AddrErr <= err_cur;
      if (!err_cur && !cur_wr) RData <= load_word;
    end
  end

endmodule
